pwm_generator: RTL and testbench

Downstream of the angle/profile stage. Turns an 8-bit duty ratio and a direction into a motor PWM waveform plus a direction pin. Ratio and direction are double-buffered: a new ratio is only applied at a PWM period boundary, so the output never glitches. pwm_done reports back to the profile stage that the requested ratio is now on the wire.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_prescaler.sv | 26 ++
 rtl/pwm_generator.sv | 156 +++++++++++++++
 tb/tb_pwm_generator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encodings and constants for the PWM generator
package pwm_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        DEADTIME = 2'd2
    } pwm_state_t;

    localparam logic [7:0] PWM_PERIOD_MAX = 8'd254;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - tick generator, one tick every PRESCALE cycles while run is high
module pwm_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(PRESCALE - 1);

    logic [7:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? 8'd0 : count + 8'd1;
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - double-buffered PWM generator with direction pin
// Optional direction-reversal deadtime: define PWM_DIR_DEADTIME_EN.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int PRESCALE         = 4,
    parameter int DEADTIME_PERIODS = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pwm_enable,
    input  logic       pwm_update,
    input  logic [7:0] pwm_ratio,
    input  logic       pwm_direction,
    output logic       pwm_done,
    output logic       pwm_out,
    output logic       dir_out,
    output logic       period_start,
    output logic [7:0] debug_signals
);

    pwm_state_t state, state_nx;
    logic [7:0] cnt, cnt_adv, cnt_nx;
    logic [7:0] active, active_nx;
    logic [7:0] shadow_ratio;
    logic       shadow_dir;
    logic       pending, pending_nx;
    logic       tick, boundary, accept, apply, dir_load;

`ifdef PWM_DIR_DEADTIME_EN
    localparam logic [7:0] DT_LAST = 8'(DEADTIME_PERIODS - 1);
    logic [7:0] dt_cnt;
    logic       dt_enter;
`else
    logic unused_deadtime;
    assign unused_deadtime = (DEADTIME_PERIODS > 0);
`endif

    pwm_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clock(clock),
        .reset(reset),
        .clear(state_nx == DISABLED),
        .run  (state != DISABLED),
        .tick (tick)
    );

    assign boundary = tick && (cnt == PWM_PERIOD_MAX);
    assign accept   = pwm_update && !pending;

    always_comb begin
        cnt_adv = cnt;
        if (tick) begin
            cnt_adv = (cnt == PWM_PERIOD_MAX) ? 8'd0 : cnt + 8'd1;
        end
    end

    // Next-state decision; outputs are registered from these next values so
    // pwm_out always agrees with the counter/state visible in the same cycle.
    always_comb begin
        state_nx = state;
        apply    = 1'b0;
`ifdef PWM_DIR_DEADTIME_EN
        dt_enter = 1'b0;
`endif
        case (state)
            DISABLED: begin
                apply = pending;
                if (pwm_enable) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!pwm_enable) begin
                    state_nx = DISABLED;
                end else if (boundary && pending) begin
`ifdef PWM_DIR_DEADTIME_EN
                    if (shadow_dir != dir_out) begin
                        state_nx = DEADTIME;
                        dt_enter = 1'b1;
                    end else begin
                        apply = 1'b1;
                    end
`else
                    apply = 1'b1;
`endif
                end
            end
`ifdef PWM_DIR_DEADTIME_EN
            DEADTIME: begin
                if (!pwm_enable) begin
                    state_nx = DISABLED;
                end else if (boundary && (dt_cnt == DT_LAST)) begin
                    state_nx = RUN;
                    apply    = 1'b1;
                end
            end
`endif
            default: state_nx = DISABLED;
        endcase
    end

`ifdef PWM_DIR_DEADTIME_EN
    assign dir_load = apply || dt_enter;
`else
    assign dir_load = apply;
`endif

    assign cnt_nx     = (state_nx == DISABLED) ? 8'd0 : cnt_adv;
    assign active_nx  = apply ? shadow_ratio : active;
    assign pending_nx = accept ? 1'b1 : (apply ? 1'b0 : pending);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= DISABLED;
            cnt          <= '0;
            active       <= '0;
            shadow_ratio <= '0;
            shadow_dir   <= DIR_CW;
            pending      <= 1'b0;
            dir_out      <= DIR_CW;
            pwm_out      <= 1'b0;
            pwm_done     <= 1'b1;
            period_start <= 1'b0;
`ifdef PWM_DIR_DEADTIME_EN
            dt_cnt       <= '0;
`endif
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            active       <= active_nx;
            pending      <= pending_nx;
            pwm_done     <= !pending_nx;
            pwm_out      <= (state_nx == RUN) && (cnt_nx < active_nx);
            period_start <= (state_nx != DISABLED) && ((state == DISABLED) || boundary);
            if (accept) begin
                shadow_ratio <= pwm_ratio;
                shadow_dir   <= pwm_direction;
            end
            if (dir_load) begin
                dir_out <= shadow_dir;
            end
`ifdef PWM_DIR_DEADTIME_EN
            if (dt_enter) begin
                dt_cnt <= '0;
            end else if ((state == DEADTIME) && boundary) begin
                dt_cnt <= dt_cnt + 8'd1;
            end
`endif
        end
    end

    assign debug_signals = {4'b0000, pending, state, pwm_out};

endmodule

// File: tb/tb_pwm_generator.sv
// tb/tb_pwm_generator.sv - directed scoreboard bench for pwm_generator (PRESCALE=1)
module tb_pwm_generator;
    import pwm_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       pwm_enable;
    logic       pwm_update;
    logic [7:0] pwm_ratio;
    logic       pwm_direction;
    logic       pwm_done;
    logic       pwm_out;
    logic       dir_out;
    logic       period_start;
    logic [7:0] debug_signals;

    pwm_generator #(
        .PRESCALE(1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pwm_enable   (pwm_enable),
        .pwm_update   (pwm_update),
        .pwm_ratio    (pwm_ratio),
        .pwm_direction(pwm_direction),
        .pwm_done     (pwm_done),
        .pwm_out      (pwm_out),
        .dir_out      (dir_out),
        .period_start (period_start),
        .debug_signals(debug_signals)
    );

    always #5 clock = ~clock;

    int    total = 0;
    int    bad   = 0;
    string tag_q[$];
    int    val_q[$];

    int   m_hi, m_ps, m_psn;
    logic m_d0, m_d1, m_dlast, m_dir0, m_dirlast;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic want(input string tag, input int val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic chk(input int obs);
        string tag;
        int    exp;
        total++;
        if (val_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = val_q.pop_front();
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
        end
    endtask

    // Runs one 255-cycle period starting on an observed period_start cycle.
    // pwm_update is held high for iterations upd_from..upd_to with a ratio
    // that changes every cycle (base at upd_from).
    task automatic period(input int upd_from, input int upd_to,
                          input logic [7:0] base, input logic dir);
        m_hi = 0;
        m_ps = 0;
        for (int i = 0; i < 255; i++) begin
            if (i == 0) begin
                m_d0   = pwm_done;
                m_dir0 = dir_out;
            end
            if (i == 1) m_d1 = pwm_done;
            if (i == 254) begin
                m_dlast   = pwm_done;
                m_dirlast = dir_out;
            end
            m_hi += int'(pwm_out);
            m_ps += int'(period_start);
            if (i >= upd_from && i <= upd_to) begin
                pwm_update    = 1'b1;
                pwm_ratio     = base + 8'((i - upd_from) * 7);
                pwm_direction = dir;
            end else begin
                pwm_update = 1'b0;
            end
            step();
        end
        m_psn = int'(period_start);
    endtask

    initial begin
        reset         = 1'b1;
        pwm_enable    = 1'b0;
        pwm_update    = 1'b0;
        pwm_ratio     = 8'd0;
        pwm_direction = DIR_CW;
        repeat (3) step();

        want("rst_pwm_out", 0); want("rst_dir_out", 0); want("rst_done", 1);
        want("rst_period_start", 0); want("rst_debug", 0);
        chk(int'(pwm_out)); chk(int'(dir_out)); chk(int'(pwm_done));
        chk(int'(period_start)); chk(int'(debug_signals));
        reset = 1'b0;
        step();

        // 1: accept while disabled, apply in DISABLED, then enable
        pwm_update = 1'b1; pwm_ratio = 8'd64; pwm_direction = DIR_CW;
        want("t1_done_low", 0); want("t1_pending", 1); want("t1_done_high", 1);
        step();
        pwm_update = 1'b0;
        chk(int'(pwm_done)); chk(int'(debug_signals[3]));
        step();
        chk(int'(pwm_done));
        pwm_enable = 1'b1;
        want("t1_first_ps", 1); want("t1_first_out", 1); want("t1_state_run", int'(RUN));
        step();
        chk(int'(period_start)); chk(int'(pwm_out)); chk(int'(debug_signals[2:1]));
        for (int p = 0; p < 2; p++) begin
            want("t1_hi", 64); want("t1_ps_count", 1); want("t1_ps_next", 1);
            period(-1, -1, 8'd0, DIR_CW);
            chk(m_hi); chk(m_ps); chk(m_psn);
        end

        // 2: ratio 100, then 200 requested mid-period
        want("t2_hi_old", 64); want("t2_done_last", 0);
        period(0, 0, 8'd100, DIR_CW);
        chk(m_hi); chk(int'(m_dlast));
        want("t2_hi_100", 100); want("t2_done_start", 1); want("t2_done_before_bnd", 0);
        period(50, 50, 8'd200, DIR_CW);
        chk(m_hi); chk(int'(m_d0)); chk(int'(m_dlast));
        want("t2_hi_200", 200); want("t2_done_after_bnd", 1); want("t2_ps_next", 1);
        period(-1, -1, 8'd0, DIR_CW);
        chk(m_hi); chk(int'(m_d0)); chk(m_psn);

        // 3: ratio 0 and ratio 255 extremes
        want("t3_hi_200", 200);
        period(0, 0, 8'd0, DIR_CW);
        chk(m_hi);
        for (int p = 0; p < 3; p++) begin
            want("t3_hi_zero", 0);
            if (p == 2) period(10, 10, 8'd255, DIR_CW);
            else        period(-1, -1, 8'd0, DIR_CW);
            chk(m_hi);
        end
        for (int p = 0; p < 2; p++) begin
            want("t3_hi_full", 255); want("t3_ps_next", 1);
            period(-1, -1, 8'd0, DIR_CW);
            chk(m_hi); chk(m_psn);
        end

        // 5: update held high with changing ratio while pending
        want("t5_hi_full", 255); want("t5_done_last", 0);
        period(0, 254, 8'd30, DIR_CW);
        chk(m_hi); chk(int'(m_dlast));
        want("t5_hi_first", 30); want("t5_done_after_apply", 1); want("t5_reaccept", 0);
        period(0, 0, 8'd77, DIR_CW);
        chk(m_hi); chk(int'(m_d0)); chk(int'(m_d1));
        want("t5_hi_second", 77);
        period(-1, -1, 8'd0, DIR_CW);
        chk(m_hi);

        // 4: direction reversal at equal ratio
        want("t4_hi_77", 77);
        period(0, 0, 8'd128, DIR_CW);
        chk(m_hi);
        want("t4_hi_cw", 128); want("t4_dir_before", int'(DIR_CW));
        period(0, 0, 8'd128, DIR_CCW);
        chk(m_hi); chk(int'(m_dirlast));
`ifdef PWM_DIR_DEADTIME_EN
        want("t4_dt1_hi", 0); want("t4_dt1_dir", int'(DIR_CCW)); want("t4_dt1_done", 0);
        period(-1, -1, 8'd0, DIR_CW);
        chk(m_hi); chk(int'(m_dir0)); chk(int'(m_d0));
        want("t4_dt2_hi", 0); want("t4_dt2_done", 0);
        period(-1, -1, 8'd0, DIR_CW);
        chk(m_hi); chk(int'(m_dlast));
        want("t4_resume_hi", 128); want("t4_resume_done", 1);
        period(-1, -1, 8'd0, DIR_CW);
        chk(m_hi); chk(int'(m_d0));
`else
        want("t4_ccw_hi", 128); want("t4_dir_after", int'(DIR_CCW)); want("t4_done", 1);
        period(-1, -1, 8'd0, DIR_CW);
        chk(m_hi); chk(int'(m_dir0)); chk(int'(m_d0));
`endif

        // 6: reset mid-period with output high
        pwm_update = 1'b0;
        repeat (120) step();
        want("t6_out_before_rst", 1);
        chk(int'(pwm_out));
        reset = 1'b1;
        step();
        want("t6_rst_out", 0); want("t6_rst_dir", 0); want("t6_rst_done", 1);
        want("t6_rst_ps", 0); want("t6_rst_debug", 0);
        chk(int'(pwm_out)); chk(int'(dir_out)); chk(int'(pwm_done));
        chk(int'(period_start)); chk(int'(debug_signals));
        reset = 1'b0;
        step();
        want("t6_restart_ps", 1);
        chk(int'(period_start));
        want("t6_hi_zero", 0); want("t6_ps_next", 1);
        period(0, 0, 8'd90, DIR_CW);
        chk(m_hi); chk(m_psn);

        // 6b: disable mid-period with a pending shadow
        for (int i = 0; i < 40; i++) begin
            pwm_update = (i == 20);
            pwm_ratio  = 8'd150;
            step();
        end
        pwm_update = 1'b0;
        want("t6_out_high_c40", 1);
        chk(int'(pwm_out));
        pwm_enable = 1'b0;
        step();
        want("t6_dis_out", 0); want("t6_dis_debug", 8'h08); want("t6_dis_done", 0);
        chk(int'(pwm_out)); chk(int'(debug_signals)); chk(int'(pwm_done));
        step();
        want("t6_dis_apply_done", 1);
        chk(int'(pwm_done));
        pwm_enable = 1'b1;
        step();
        want("t6_reen_ps", 1); want("t6_reen_out", 1);
        chk(int'(period_start)); chk(int'(pwm_out));
        want("t6_hi_150", 150); want("t6_ps_next", 1);
        period(-1, -1, 8'd0, DIR_CW);
        chk(m_hi); chk(m_psn);

        if (val_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", val_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
